jpeg_idct_transpose: RTL and testbench

JPEG_IDCT_TRANSPOSE -- requirements
Module: jpeg_idct_transpose

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/jpeg_tp_bank.sv | 107 ++++++++++
 rtl/jpeg_idct_transpose.sv | 136 +++++++++++++
 tb/tb_jpeg_idct_transpose.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_pkg
// Purpose : Shared types and constants for the IDCT transpose buffer.
//           BLK_WORDS - words per 8x8 block
//           BEATS     - output beats per block (8 rows x 2 halves)
//           COEF_W    - coefficient word width
// Revision: 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    localparam int BLK_WORDS = 64;
    localparam int BEATS     = 16;
    localparam int COEF_W    = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rd_state_t;

    // Bank storage is row-major: address = {row, col}. The incoming index
    // carries the row in [2:0] and the column in [5:3].
    function automatic logic [5:0] wr_addr(input logic [5:0] idx);
        return {idx[2:0], idx[5:3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_tp_bank.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_tp_bank
// Purpose : One 8x8 coefficient bank with write count, written mask and
//           full flag. Reads return four consecutive columns of one row;
//           positions never written in this block read as zero.
// Ports   : clk_i, rst_ni         clock, async active-low reset
//           clr_i                 synchronous clear of count/mask/full
//           wr_en_i, wr_idx_i,    word write (idx[2:0]=row, idx[5:3]=col)
//           wr_data_i
//           flush_i               end of image while this is the write bank
//           rd_row_i, rd_half_i   read row and column half
//           full_o                bank holds a complete block
//           fill_o                bank becomes full on this edge
//           rd_data0_o..3_o       columns half*4+0 .. half*4+3
// Revision: 1.0 - initial release
// ============================================================================
module jpeg_tp_bank
    import jpeg_pkg::*;
#(
    parameter int ZERO_FILL = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [5:0]        wr_idx_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic              flush_i,
    input  logic [2:0]        rd_row_i,
    input  logic              rd_half_i,
    output logic              full_o,
    output logic              fill_o,
    output logic [COEF_W-1:0] rd_data0_o,
    output logic [COEF_W-1:0] rd_data1_o,
    output logic [COEF_W-1:0] rd_data2_o,
    output logic [COEF_W-1:0] rd_data3_o
);

    logic [COEF_W-1:0]    r_mem [BLK_WORDS];
    logic [BLK_WORDS-1:0] r_mask;
    logic [6:0]           r_count;
    logic                 r_full;

    logic [5:0]           w_wr_addr;
    logic [6:0]           w_count_nxt;
    logic                 w_discard;
    logic [COEF_W-1:0]    w_rd_data [4];

    assign w_wr_addr   = wr_addr(wr_idx_i);
    // A same-cycle write is counted before the flush decision.
    assign w_count_nxt = r_count + {6'd0, wr_en_i};

    assign fill_o = !r_full && !clr_i &&
                    ((w_count_nxt == 7'(BLK_WORDS)) ||
                     (flush_i && (ZERO_FILL != 0) && (w_count_nxt != 7'd0)));

    assign w_discard = (ZERO_FILL == 0) && flush_i && !r_full &&
                       (w_count_nxt != 7'd0) && (w_count_nxt != 7'(BLK_WORDS));

    assign full_o = r_full;

    // Contents need no reset: the mask decides what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[w_wr_addr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 7'd0;
            r_mask  <= '0;
            r_full  <= 1'b0;
        end else if (clr_i) begin
            r_count <= 7'd0;
            r_mask  <= '0;
            r_full  <= 1'b0;
        end else if (w_discard) begin
            r_count <= 7'd0;
            r_mask  <= '0;
        end else begin
            if (wr_en_i) begin
                r_count            <= w_count_nxt;
                r_mask[w_wr_addr]  <= 1'b1;
            end
            if (fill_o) begin
                r_full <= 1'b1;
            end
        end
    end

    generate
        for (genvar j = 0; j < 4; j++) begin : g_rd
            logic [5:0] w_addr;
            assign w_addr       = {rd_row_i, rd_half_i, 2'(j)};
            assign w_rd_data[j] = r_mask[w_addr] ? r_mem[w_addr] : '0;
        end
    endgenerate

    assign rd_data0_o = w_rd_data[0];
    assign rd_data1_o = w_rd_data[1];
    assign rd_data2_o = w_rd_data[2];
    assign rd_data3_o = w_rd_data[3];

endmodule
`default_nettype wire

// File: rtl/jpeg_idct_transpose.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_idct_transpose
// Purpose : Ping-pong 8x8 transpose buffer between the row and column IDCT
//           stages. Words arrive in any order by index; each complete block
//           is emitted as 16 registered beats of four columns of one row.
// Ports   : clk_i, rst_ni                 clock, async active-low reset
//           img_start_i                   abort everything, restart
//           img_end_i                     flush a partial write block
//           inport_valid_i/_data_i/_idx_i input word (idx[2:0]=row,[5:3]=col)
//           inport_accept_o               write bank not full
//           outport_valid_o               beat valid (no backpressure)
//           outport_data0_o..3_o          columns half*4+0..3 of the row
//           outport_idx_o, outport_half_o row and column half of the beat
// Revision: 1.0 - initial release
// ============================================================================
module jpeg_idct_transpose
    import jpeg_pkg::*;
#(
    parameter int ZERO_FILL = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              img_start_i,
    input  logic              img_end_i,
    input  logic              inport_valid_i,
    input  logic [31:0]       inport_data_i,
    input  logic [5:0]        inport_idx_i,
    output logic              inport_accept_o,
    output logic              outport_valid_o,
    output logic [31:0]       outport_data0_o,
    output logic [31:0]       outport_data1_o,
    output logic [31:0]       outport_data2_o,
    output logic [31:0]       outport_data3_o,
    output logic [2:0]        outport_idx_o,
    output logic              outport_half_o
);

    rd_state_t         r_state;
    logic [3:0]        r_beat;
    logic              r_wr_ptr;
    logic              r_rd_ptr;

    logic [1:0]        w_full;
    logic [1:0]        w_fill;
    logic [COEF_W-1:0] w_rd_data [2][4];
    logic              w_wr_fire;
    logic              w_last_beat;

    assign inport_accept_o = !w_full[r_wr_ptr];
    assign w_wr_fire       = inport_valid_i && inport_accept_o && !img_start_i;
    assign w_last_beat     = (r_state == ST_DRAIN) && (r_beat == 4'(BEATS - 1));

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            jpeg_tp_bank #(
                .ZERO_FILL (ZERO_FILL)
            ) u_bank (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .clr_i      (img_start_i || (w_last_beat && (r_rd_ptr == 1'(b)))),
                .wr_en_i    (w_wr_fire && (r_wr_ptr == 1'(b))),
                .wr_idx_i   (inport_idx_i),
                .wr_data_i  (inport_data_i),
                .flush_i    (img_end_i && !img_start_i && (r_wr_ptr == 1'(b))),
                .rd_row_i   (r_beat[3:1]),
                .rd_half_i  (r_beat[0]),
                .full_o     (w_full[b]),
                .fill_o     (w_fill[b]),
                .rd_data0_o (w_rd_data[b][0]),
                .rd_data1_o (w_rd_data[b][1]),
                .rd_data2_o (w_rd_data[b][2]),
                .rd_data3_o (w_rd_data[b][3])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= ST_IDLE;
            r_beat          <= 4'd0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            outport_valid_o <= 1'b0;
            outport_data0_o <= '0;
            outport_data1_o <= '0;
            outport_data2_o <= '0;
            outport_data3_o <= '0;
            outport_idx_o   <= 3'd0;
            outport_half_o  <= 1'b0;
        end else if (img_start_i) begin
            // Row/half keep their last value; only valid is forced low.
            r_state         <= ST_IDLE;
            r_beat          <= 4'd0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            outport_valid_o <= 1'b0;
        end else begin
            outport_valid_o <= 1'b0;
            if (w_fill[r_wr_ptr]) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_full[r_rd_ptr]) begin
                        r_state <= ST_DRAIN;
                        r_beat  <= 4'd0;
                    end
                end
                ST_DRAIN: begin
                    outport_valid_o <= 1'b1;
                    outport_data0_o <= w_rd_data[r_rd_ptr][0];
                    outport_data1_o <= w_rd_data[r_rd_ptr][1];
                    outport_data2_o <= w_rd_data[r_rd_ptr][2];
                    outport_data3_o <= w_rd_data[r_rd_ptr][3];
                    outport_idx_o   <= r_beat[3:1];
                    outport_half_o  <= r_beat[0];
                    if (w_last_beat) begin
                        r_rd_ptr <= ~r_rd_ptr;
                        r_beat   <= 4'd0;
                        // Stay in DRAIN when the other bank is already
                        // waiting, so consecutive blocks run gap-free.
                        if (!w_full[~r_rd_ptr]) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_beat <= r_beat + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_idct_transpose.sv
`default_nettype none
// ============================================================================
// Module  : tb_jpeg_idct_transpose
// Purpose : Self-checking bench for jpeg_idct_transpose. A ZERO_FILL=1 and a
//           ZERO_FILL=0 instance share the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jpeg_idct_transpose;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        img_start_i = 1'b0;
    logic        img_end_i = 1'b0;
    logic        inport_valid_i = 1'b0;
    logic [31:0] inport_data_i = '0;
    logic [5:0]  inport_idx_i = '0;

    logic        inport_accept_o, outport_valid_o, outport_half_o;
    logic [31:0] outport_data0_o, outport_data1_o, outport_data2_o, outport_data3_o;
    logic [2:0]  outport_idx_o;

    logic        nz_accept, nz_valid, nz_half;
    logic [31:0] nz_d0, nz_d1, nz_d2, nz_d3;
    logic [2:0]  nz_idx;

    jpeg_idct_transpose #(.ZERO_FILL(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .img_start_i(img_start_i), .img_end_i(img_end_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i), .inport_idx_i(inport_idx_i),
        .inport_accept_o(inport_accept_o), .outport_valid_o(outport_valid_o),
        .outport_data0_o(outport_data0_o), .outport_data1_o(outport_data1_o),
        .outport_data2_o(outport_data2_o), .outport_data3_o(outport_data3_o),
        .outport_idx_o(outport_idx_o), .outport_half_o(outport_half_o)
    );

    jpeg_idct_transpose #(.ZERO_FILL(0)) dut_nz (
        .clk_i(clk_i), .rst_ni(rst_ni), .img_start_i(img_start_i), .img_end_i(img_end_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i), .inport_idx_i(inport_idx_i),
        .inport_accept_o(nz_accept), .outport_valid_o(nz_valid),
        .outport_data0_o(nz_d0), .outport_data1_o(nz_d1),
        .outport_data2_o(nz_d2), .outport_data3_o(nz_d3),
        .outport_idx_o(nz_idx), .outport_half_o(nz_half)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nz_beats = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  row;
        logic        half;
        logic [31:0] d0, d1, d2, d3;
    } beat_t;

    typedef struct {
        int          grp;
        int          beat;
        int          row;
        int          half;
        logic [31:0] d0, d1, d2, d3;
    } vec_t;

    beat_t q[$];
    vec_t  tbl[$];

    always @(negedge clk_i) begin
        if (outport_valid_o)
            q.push_back('{cyc, outport_idx_o, outport_half_o,
                          outport_data0_o, outport_data1_o, outport_data2_o, outport_data3_o});
        if (nz_valid) nz_beats <= nz_beats + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic put(input logic [5:0] idx, input logic [31:0] data, input logic endf,
                       output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk_i);
        inport_valid_i = 1'b1;
        inport_idx_i   = idx;
        inport_data_i  = data;
        img_end_i      = endf;
        while (!inport_accept_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL accept_wait: got 0 expected 1 within 100 cycles");
        end
        @(posedge clk_i);
        #1;
        acc_cyc        = cyc;
        inport_valid_i = 1'b0;
        img_end_i      = 1'b0;
    endtask

    task automatic write_block(input int off, output int last_cyc);
        for (int i = 0; i < 64; i++) put(6'(i), 32'(i + off), 1'b0, last_cyc);
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        img_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        img_start_i = 1'b0;
    endtask

    task automatic wait_beats(input int total, input string nm);
        int k;
        k = 0;
        while (q.size() < total && k < 300) begin
            @(posedge clk_i);
            #2;
            k++;
        end
        repeat (20) @(posedge clk_i);
        #2;
        chk({nm, "_beat_count"}, 32'(q.size()), 32'(total));
    endtask

    // Full block written with data = idx + off: element(row,col) = col*8+row+off.
    task automatic chk_block(input int base, input int off, input string nm);
        for (int i = 0; i < 16; i++) begin
            beat_t       b;
            logic [31:0] dv [4];
            int          r, h;
            if (base + i >= q.size()) begin
                checks++;
                failures++;
                $display("FAIL %s_missing_beat%0d: got none expected beat", nm, i);
                continue;
            end
            r = i / 2;
            h = i % 2;
            b = q[base + i];
            dv = '{b.d0, b.d1, b.d2, b.d3};
            chk($sformatf("%s_b%0d_row", nm, i), 32'(b.row), 32'(r));
            chk($sformatf("%s_b%0d_half", nm, i), 32'(b.half), 32'(h));
            chk($sformatf("%s_b%0d_cyc", nm, i), 32'(b.cyc), 32'(q[base].cyc + i));
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s_b%0d_d%0d", nm, i, j), dv[j], 32'(off + (h * 4 + j) * 8 + r));
        end
    endtask

    task automatic chk_tbl(input int grp, input int base);
        foreach (tbl[i]) begin
            if (tbl[i].grp == grp) begin
                beat_t b;
                string nm;
                nm = $sformatf("tbl_g%0d_b%0d", grp, tbl[i].beat);
                if (base + tbl[i].beat >= q.size()) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: got no beat expected beat", nm);
                    continue;
                end
                b = q[base + tbl[i].beat];
                chk({nm, "_row"}, 32'(b.row), 32'(tbl[i].row));
                chk({nm, "_half"}, 32'(b.half), 32'(tbl[i].half));
                chk({nm, "_d0"}, b.d0, tbl[i].d0);
                chk({nm, "_d1"}, b.d1, tbl[i].d1);
                chk({nm, "_d2"}, b.d2, tbl[i].d2);
                chk({nm, "_d3"}, b.d3, tbl[i].d3);
            end
        end
    endtask

    localparam int G_FULL = 0;
    localparam int G_ZF   = 1;
    localparam int G_BP   = 2;
    localparam int G_DUP  = 3;

    initial begin
        int base, nz_base, c0, c1, c2, k;
        int wl[3];

        // grp, beat, row, half, d0..d3
        tbl.push_back('{G_FULL,  0, 0, 0,  0,  8, 16, 24});
        tbl.push_back('{G_FULL,  1, 0, 1, 32, 40, 48, 56});
        tbl.push_back('{G_FULL,  6, 3, 0,  3, 11, 19, 27});
        tbl.push_back('{G_FULL, 15, 7, 1, 39, 47, 55, 63});
        tbl.push_back('{G_ZF,    0, 0, 0,  0,  8,  0,  0});
        tbl.push_back('{G_ZF,    1, 0, 1,  0,  0,  0,  0});
        tbl.push_back('{G_ZF,    2, 1, 0,  1,  9,  0,  0});
        tbl.push_back('{G_ZF,    4, 2, 0,  2,  0,  0,  0});
        tbl.push_back('{G_ZF,   15, 7, 1,  0,  0,  0,  0});
        tbl.push_back('{G_BP,    0, 0, 0, 11,  0,  0,  0});
        tbl.push_back('{G_BP,   18, 1, 0,  0, 22,  0,  0});
        tbl.push_back('{G_BP,   36, 2, 0,  0,  0, 33,  0});
        tbl.push_back('{G_DUP,   0, 0, 0, 88,  8, 16, 24});
        tbl.push_back('{G_DUP,  14, 7, 0,  7, 15, 23, 31});
        tbl.push_back('{G_DUP,  15, 7, 1, 39, 47, 55,  0});

        // Reset state
        #12;
        chk("rst_valid", 32'(outport_valid_o), 32'd0);
        chk("rst_idx", 32'(outport_idx_o), 32'd0);
        chk("rst_half", 32'(outport_half_o), 32'd0);
        chk("rst_data", outport_data0_o | outport_data1_o | outport_data2_o | outport_data3_o, 32'd0);
        chk("rst_accept", 32'(inport_accept_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single in-order block
        pulse_start();
        base = q.size();
        write_block(0, c0);
        wait_beats(base + 16, "full");
        if (q.size() > base) chk("full_latency", 32'(q[base].cyc), 32'(c0 + 2));
        chk_block(base, 0, "full");
        chk_tbl(G_FULL, base);

        // Three consecutive blocks
        pulse_start();
        base = q.size();
        for (int blk = 0; blk < 3; blk++) write_block((blk + 1) * 1000, wl[blk]);
        wait_beats(base + 48, "b2b");
        for (int blk = 0; blk < 3; blk++) begin
            if (q.size() > base + blk * 16)
                chk($sformatf("b2b_latency%0d", blk), 32'(q[base + blk * 16].cyc), 32'(wl[blk] + 2));
            chk_block(base + blk * 16, (blk + 1) * 1000, $sformatf("b2b%0d", blk));
        end

        // Both banks full: short blocks closed by img_end in the write cycle
        pulse_start();
        base = q.size();
        nz_base = nz_beats;
        put(6'd0, 32'd11, 1'b1, c0);
        put(6'd9, 32'd22, 1'b1, c1);
        @(negedge clk_i);
        chk("bp_accept_low", 32'(inport_accept_o), 32'd0);
        put(6'd18, 32'd33, 1'b1, c2);
        wait_beats(base + 48, "bp");
        if (q.size() >= base + 48) begin
            chk("bp_accept_rise", 32'(c2), 32'(q[base + 15].cyc + 1));
            chk("bp_gap01", 32'(q[base + 16].cyc - q[base + 15].cyc <= 2), 32'd1);
            chk("bp_gap12", 32'(q[base + 32].cyc - q[base + 31].cyc <= 2), 32'd1);
            chk("bp_latency", 32'(q[base].cyc), 32'(c0 + 2));
        end
        chk_tbl(G_BP, base);
        chk("bp_nz_beats", 32'(nz_beats - nz_base), 32'd0);

        // Partial block flushed by a standalone img_end
        pulse_start();
        base = q.size();
        nz_base = nz_beats;
        for (int i = 0; i < 10; i++) put(6'(i), 32'(i), 1'b0, c0);
        @(negedge clk_i);
        img_end_i = 1'b1;
        @(posedge clk_i);
        #1;
        c1 = cyc;
        img_end_i = 1'b0;
        wait_beats(base + 16, "zf");
        if (q.size() > base) chk("zf_latency", 32'(q[base].cyc), 32'(c1 + 2));
        chk_tbl(G_ZF, base);
        chk("nz_beats", 32'(nz_beats - nz_base), 32'd0);
        chk("nz_accept", 32'(nz_accept), 32'd1);

        // img_start during beat 5 of a drain
        pulse_start();
        base = q.size();
        write_block(500, c0);
        k = 0;
        while (k < 50) begin
            @(negedge clk_i);
            k++;
            if (outport_valid_o && outport_idx_o == 3'd2 && outport_half_o) break;
        end
        img_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        img_start_i = 1'b0;
        @(negedge clk_i);
        chk("abort_valid", 32'(outport_valid_o), 32'd0);
        repeat (20) @(negedge clk_i);
        chk("abort_beats", 32'(q.size()), 32'(base + 6));
        base = q.size();
        write_block(0, c0);
        wait_beats(base + 16, "after_abort");
        chk_block(base, 0, "after_abort");

        // Reset in the middle of a fill
        for (int i = 0; i < 30; i++) put(6'(i), 32'(i + 900), 1'b0, c0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("mrst_valid", 32'(outport_valid_o), 32'd0);
        chk("mrst_idx", 32'(outport_idx_o), 32'd0);
        chk("mrst_half", 32'(outport_half_o), 32'd0);
        chk("mrst_data", outport_data0_o | outport_data1_o | outport_data2_o | outport_data3_o, 32'd0);
        chk("mrst_accept", 32'(inport_accept_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        base = q.size();
        write_block(0, c0);
        wait_beats(base + 16, "after_rst");
        chk_tbl(G_FULL, base);

        // Duplicate index 0, index 63 never written
        pulse_start();
        base = q.size();
        put(6'd0, 32'd77, 1'b0, c0);
        put(6'd0, 32'd88, 1'b0, c0);
        for (int i = 1; i < 63; i++) put(6'(i), 32'(i), 1'b0, c0);
        wait_beats(base + 16, "dup");
        chk_tbl(G_DUP, base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
